// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer for the 5-stage core.
// Merges hazard, branch, memory-busy and HALT into per-register
// enable/flush/bubble controls. Also runs the halt-drain FSM, a stall
// watchdog and saturating performance counters.
module pipe_seq_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MAX_STALL    = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             ip_clock,
  input  logic             ip_reset,
  input  logic             ip_stall_req,
  input  logic             ip_branch_taken,
  input  logic             ip_mem_busy,
  input  logic             ip_halt,
  output logic             op_PC_en,
  output logic             op_IFID_en,
  output logic             op_IFID_flush,
  output logic             op_IDEX_bubble,
  output logic             op_pipe_en,
  output logic             op_halted,
  output logic             op_deadlock,
  output logic [CNT_W-1:0] op_stall_cycles,
  output logic [CNT_W-1:0] op_flush_count
);

  localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned STL_W = 8;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t             r_state;
  logic [DRN_W-1:0]   r_drain_cnt;
  logic [STL_W-1:0]   r_consec;
  logic               r_deadlock;
  logic [CNT_W-1:0]   r_stall_cycles;
  logic [CNT_W-1:0]   r_flush_count;

  // Per-cycle event decode, shared by the outputs and the state update
  logic w_flush_ev;
  logic w_halt_ev;
  logic w_stall_ev;
  logic w_run_ev;

  // Control outputs and event decode from current state and inputs
  always_comb begin
    op_PC_en       = 1'b0;
    op_IFID_en     = 1'b0;
    op_IFID_flush  = 1'b0;
    op_IDEX_bubble = 1'b0;
    op_pipe_en     = 1'b0;
    w_flush_ev     = 1'b0;
    w_halt_ev      = 1'b0;
    w_stall_ev     = 1'b0;
    w_run_ev       = 1'b0;
    if (ip_reset) begin
      op_IFID_flush  = 1'b1;
      op_IDEX_bubble = 1'b1;
    end else begin
      case (r_state)
        S_RUN: begin
          if (ip_mem_busy) begin
            // full freeze: everything already 0
          end else if (ip_branch_taken) begin
            op_PC_en       = 1'b1;
            op_IFID_en     = 1'b1;
            op_IFID_flush  = 1'b1;
            op_IDEX_bubble = 1'b1;
            op_pipe_en     = 1'b1;
            w_flush_ev     = 1'b1;
          end else if (ip_halt) begin
            op_IDEX_bubble = 1'b1;
            op_pipe_en     = 1'b1;
            w_halt_ev      = 1'b1;
          end else if (ip_stall_req) begin
            op_IDEX_bubble = 1'b1;
            op_pipe_en     = 1'b1;
            w_stall_ev     = 1'b1;
          end else begin
            op_PC_en   = 1'b1;
            op_IFID_en = 1'b1;
            op_pipe_en = 1'b1;
            w_run_ev   = 1'b1;
          end
        end
        S_DRAIN: begin
          op_IDEX_bubble = 1'b1;
          op_pipe_en     = !ip_mem_busy;
          // taken branch behind the HALT means the HALT was speculative
          if (!ip_mem_busy && ip_branch_taken) begin
            op_PC_en      = 1'b1;
            op_IFID_en    = 1'b1;
            op_IFID_flush = 1'b1;
            w_flush_ev    = 1'b1;
          end
        end
        default: begin
          // HALTED: everything held off
        end
      endcase
    end
  end

  // Status outputs; reset masks them immediately
  assign op_halted       = (r_state == S_HALTED) && !ip_reset;
  assign op_deadlock     = r_deadlock && !ip_reset;
  assign op_stall_cycles = ip_reset ? '0 : r_stall_cycles;
  assign op_flush_count  = ip_reset ? '0 : r_flush_count;

  // State, drain counter, watchdog and performance counters
  always_ff @(posedge ip_clock) begin
    if (ip_reset) begin
      r_state        <= S_RUN;
      r_drain_cnt    <= '0;
      r_consec       <= '0;
      r_deadlock     <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_flush_ev && (r_flush_count != '1))
        r_flush_count <= r_flush_count + CNT_W'(1);

      if (w_stall_ev) begin
        if (r_stall_cycles != '1)
          r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        if (r_consec != '1)
          r_consec <= r_consec + STL_W'(1);
        if (r_consec == STL_W'(MAX_STALL - 1))
          r_deadlock <= 1'b1;
      end

      if (w_flush_ev || w_halt_ev || w_run_ev)
        r_consec <= '0;

      case (r_state)
        S_RUN: begin
          if (w_halt_ev) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= DRN_W'(DRAIN_CYCLES - 1);
          end
        end
        S_DRAIN: begin
          if (!ip_mem_busy) begin
            if (ip_branch_taken)
              r_state <= S_RUN;
            else if (r_drain_cnt == '0)
              r_state <= S_HALTED;
            else
              r_drain_cnt <= r_drain_cnt - DRN_W'(1);
          end
        end
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed bench for pipe_seq_ctrl with an expectation queue.
module tb_pipe_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall, br, busy, halt;
  logic pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en, halted, deadlock;
  logic [15:0] stall_cycles, flush_count;
  logic s_pc_en, s_ifid_en, s_ifid_flush, s_idex_bubble, s_pipe_en, s_halted, s_deadlock;
  logic [3:0] s_stall_cycles, s_flush_count;

  pipe_seq_ctrl u_dut (
    .ip_clock(clk), .ip_reset(rst), .ip_stall_req(stall), .ip_branch_taken(br),
    .ip_mem_busy(busy), .ip_halt(halt),
    .op_PC_en(pc_en), .op_IFID_en(ifid_en), .op_IFID_flush(ifid_flush),
    .op_IDEX_bubble(idex_bubble), .op_pipe_en(pipe_en), .op_halted(halted),
    .op_deadlock(deadlock), .op_stall_cycles(stall_cycles), .op_flush_count(flush_count)
  );

  pipe_seq_ctrl #(.CNT_W(4)) u_sat (
    .ip_clock(clk), .ip_reset(rst), .ip_stall_req(stall), .ip_branch_taken(br),
    .ip_mem_busy(busy), .ip_halt(halt),
    .op_PC_en(s_pc_en), .op_IFID_en(s_ifid_en), .op_IFID_flush(s_ifid_flush),
    .op_IDEX_bubble(s_idex_bubble), .op_pipe_en(s_pipe_en), .op_halted(s_halted),
    .op_deadlock(s_deadlock), .op_stall_cycles(s_stall_cycles), .op_flush_count(s_flush_count)
  );

  // {PC_en, IFID_en, IFID_flush, IDEX_bubble, pipe_en}
  localparam logic [4:0] C_RST = 5'b00110;
  localparam logic [4:0] C_RUN = 5'b11001;
  localparam logic [4:0] C_FLS = 5'b11111;
  localparam logic [4:0] C_STL = 5'b00011;
  localparam logic [4:0] C_DBZ = 5'b00010;
  localparam logic [4:0] C_OFF = 5'b00000;

  typedef struct {
    logic [4:0] ctrl;
    logic       halted;
    int         stall;
    int         flush;
    logic       dl;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_err = 0;
  int n_step = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, n_step, obs, exp);
    end
  endtask

  // One cycle: drive inputs, queue expectations, check controls before
  // the edge and registered state after it.
  task automatic step(input logic i_rst, i_stall, i_br, i_busy, i_halt,
                      input logic [4:0] e_ctrl, input logic e_halted,
                      input int e_stall, input int e_flush, input logic e_dl);
    exp_t e;
    @(negedge clk);
    n_step++;
    rst = i_rst; stall = i_stall; br = i_br; busy = i_busy; halt = i_halt;
    e.ctrl = e_ctrl; e.halted = e_halted; e.stall = e_stall; e.flush = e_flush; e.dl = e_dl;
    q.push_back(e);
    #1;
    e = q.pop_front();
    chk("ctrl", 32'({pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en}), 32'(e.ctrl));
    chk("halted", 32'(halted), 32'(e.halted));
    @(posedge clk);
    #1;
    chk("stall_cycles", 32'(stall_cycles), 32'(e.stall));
    chk("flush_count", 32'(flush_count), 32'(e.flush));
    chk("deadlock", 32'(deadlock), 32'(e.dl));
    chk("sat_flush", 32'(s_flush_count), 32'((e.flush > 15) ? 15 : e.flush));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br = 1'b0; busy = 1'b0; halt = 1'b0;
    // reset state
    step(1, 0, 0, 0, 0, C_RST, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, C_RST, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, C_RUN, 0, 0, 0, 0);
    // three hazard stalls then release
    step(0, 1, 0, 0, 0, C_STL, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, C_STL, 0, 2, 0, 0);
    step(0, 1, 0, 0, 0, C_STL, 0, 3, 0, 0);
    step(0, 0, 0, 0, 0, C_RUN, 0, 3, 0, 0);
    // branch beats stall
    step(0, 1, 1, 0, 0, C_FLS, 0, 3, 1, 0);
    step(0, 0, 0, 0, 0, C_RUN, 0, 3, 1, 0);
    // memory busy freezes everything, even over branch/stall
    step(0, 1, 1, 1, 0, C_OFF, 0, 3, 1, 0);
    // halt drain with busy on the second drain cycle
    step(0, 0, 0, 0, 1, C_STL, 0, 3, 1, 0);
    step(0, 1, 0, 0, 1, C_STL, 0, 3, 1, 0);
    step(0, 0, 0, 1, 0, C_DBZ, 0, 3, 1, 0);
    step(0, 0, 0, 0, 0, C_STL, 0, 3, 1, 0);
    step(0, 0, 0, 0, 0, C_STL, 0, 3, 1, 0);
    for (int i = 0; i < 10; i++)
      step(0, i[0], i[1], i[2], 1, C_OFF, 1, 3, 1, 0);
    // reset leaves HALTED; halt followed by branch returns to RUN
    step(1, 0, 0, 0, 0, C_RST, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, C_STL, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, C_FLS, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 0, C_RUN, 0, 0, 1, 0);
    // watchdog trips on the 16th consecutive stall edge
    for (int i = 1; i <= 16; i++)
      step(0, 1, 0, 0, 0, C_STL, 0, i, 1, (i == 16) ? 1'b1 : 1'b0);
    step(0, 0, 0, 0, 0, C_RUN, 0, 16, 1, 1);
    step(0, 0, 0, 0, 0, C_RUN, 0, 16, 1, 1);
    step(1, 0, 0, 0, 0, C_RST, 0, 0, 0, 0);
    // 20 flushes; the 4-bit instance saturates at 15
    for (int i = 1; i <= 20; i++)
      step(0, 0, 1, 0, 0, C_FLS, 0, 0, i, 0);
    step(0, 0, 0, 0, 0, C_RUN, 0, 0, 20, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
